// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: default bus widths, the "no label" tag used by
// reservation stations and the ROB, and the arbitration mode encoding.
package cdb_arbiter_pkg;

  localparam int CDB_DATA_W  = 32;
  localparam int CDB_LABEL_W = 5;

  // Label value meaning "no producer"; also the CDB label after reset.
  localparam logic [CDB_LABEL_W-1:0] CDB_NO_LABEL = '0;

  typedef enum logic {
    ARB_FIXED = 1'b0,  // highest requesting index wins
    ARB_RR    = 1'b1   // round-robin starting at the pointer
  } arb_mode_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the common data bus.
//
// Handshake: a producer raises src_valid[i] with src_data/src_label for
// channel i and holds them stable until src_ready[i] is seen high; a
// transfer happens in a cycle where src_valid[i] & src_ready[i]. src_ready
// is one-hot or zero and never set for a channel that is not valid. The
// broadcast side (cdb_*) is a pure registered output with no back-pressure.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int LABEL_W = CDB_LABEL_W
);

  logic [N_SRC-1:0]         src_valid;
  logic [N_SRC*DATA_W-1:0]  src_data;
  logic [N_SRC*LABEL_W-1:0] src_label;
  logic [N_SRC-1:0]         src_ready;
  logic                     cdb_valid;
  logic [DATA_W-1:0]        cdb_data;
  logic [LABEL_W-1:0]       cdb_label;
  logic [N_SRC-1:0]         cdb_src;

  // Producers and CDB consumers.
  modport master (
    output src_valid, src_data, src_label,
    input  src_ready, cdb_valid, cdb_data, cdb_label, cdb_src
  );

  // The arbiter.
  modport slave (
    input  src_valid, src_data, src_label,
    output src_ready, cdb_valid, cdb_data, cdb_label, cdb_src
  );

endinterface

// File: rtl/cdb_rr_pick.sv
// Combinational one-hot picker: round-robin from ptr, or fixed priority
// with the highest requesting index winning.
module cdb_rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter  int N_SRC = 4,
  localparam int PTR_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  arb_mode_e        mode,
  output logic [N_SRC-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan requests and raise exactly one grant bit for the winner.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (mode == ARB_RR) begin
      for (int k = 0; k < N_SRC; k++) begin
        idx = PTR_W'((int'(ptr) + k) % N_SRC);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (req[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one completed result per cycle from the
// functional-unit producers and broadcasts it one cycle later on a
// registered CDB. Losing producers simply hold their request.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int N_SRC   = 4,
  parameter  int DATA_W  = CDB_DATA_W,
  parameter  int LABEL_W = CDB_LABEL_W,
  parameter  int RR_MODE = 1,
  localparam int PTR_W   = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  cdb_arbiter_if.slave     bus,
  output logic [PTR_W-1:0] dbg_ptr
);

  localparam arb_mode_e MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  logic [PTR_W-1:0]   ptr_q;
  logic [N_SRC-1:0]   pick;
  logic [N_SRC-1:0]   grant;
  logic               xfer;
  logic [PTR_W-1:0]   g_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [DATA_W-1:0]  mux_data;
  logic [LABEL_W-1:0] mux_label;

  logic               cdb_valid_q;
  logic [DATA_W-1:0]  cdb_data_q;
  logic [LABEL_W-1:0] cdb_label_q;
  logic [N_SRC-1:0]   cdb_src_q;

  cdb_rr_pick #(.N_SRC(N_SRC)) u_pick (
    .req   (bus.src_valid),
    .ptr   (ptr_q),
    .mode  (MODE),
    .grant (pick)
  );

  // Flush squashes the grant; ready is also held low while in reset.
  always_comb begin
    grant = (flush || !rst_n) ? '0 : pick;
    xfer  = |grant;
  end

  // One-hot mux of the winner's data/label and its index for the pointer.
  always_comb begin
    mux_data  = '0;
    mux_label = '0;
    g_idx     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        mux_data  = mux_data  | bus.src_data[i*DATA_W +: DATA_W];
        mux_label = mux_label | bus.src_label[i*LABEL_W +: LABEL_W];
        g_idx     = PTR_W'(i);
      end
    end
    next_ptr = (g_idx == PTR_W'(N_SRC - 1)) ? '0 : g_idx + 1'b1;
  end

  // Broadcast registers and RR pointer; data/label hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_label_q <= CDB_NO_LABEL;
      cdb_src_q   <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      cdb_valid_q <= 1'b1;
      cdb_data_q  <= mux_data;
      cdb_label_q <= mux_label;
      cdb_src_q   <= grant;
      if (MODE == ARB_RR) begin
        ptr_q <= next_ptr;
      end
    end else begin
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= '0;
    end
  end

  assign bus.src_ready = grant;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_label = cdb_label_q;
  assign bus.cdb_src   = cdb_src_q;
  assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a round-robin instance and a fixed-priority
// instance, checked against a behavioural model of the arbitration rules.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 5;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] dbg_ptr_rr;
  logic [1:0] dbg_ptr_fx;

  int total;
  int bad;

  cdb_arbiter_if #(.N_SRC(N), .DATA_W(DW), .LABEL_W(LW)) bus_rr ();
  cdb_arbiter_if #(.N_SRC(N), .DATA_W(DW), .LABEL_W(LW)) bus_fx ();

  cdb_arbiter #(.N_SRC(N), .DATA_W(DW), .LABEL_W(LW), .RR_MODE(1)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus_rr),
    .dbg_ptr (dbg_ptr_rr)
  );

  cdb_arbiter #(.N_SRC(N), .DATA_W(DW), .LABEL_W(LW), .RR_MODE(0)) u_fx (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus_fx),
    .dbg_ptr (dbg_ptr_fx)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (RR instance) ----------------
  int          m_ptr;
  logic        m_valid;
  logic [31:0] m_data;
  logic [4:0]  m_label;
  logic [3:0]  m_src;
  logic [31:0] exp_q[$];

  // Which channel wins under the arbitration rules; returns one-hot or 0.
  function automatic logic [3:0] ref_grant(input logic [3:0] v, input int p,
                                           input bit rr, input bit fl);
    logic [3:0] g;
    g = '0;
    if (fl || v == 4'b0000) return g;
    if (rr) begin
      for (int k = 0; k < N; k++) begin
        if (v[(p + k) % N]) begin
          g[(p + k) % N] = 1'b1;
          return g;
        end
      end
    end else begin
      for (int c = N - 1; c >= 0; c--) begin
        if (v[c]) begin
          g[c] = 1'b1;
          return g;
        end
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_label = '0;
    m_src   = '0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic model_tick();
    logic [3:0] g;
    g = ref_grant(bus_rr.src_valid, m_ptr, 1'b1, flush);
    if (g != 4'b0000) begin
      for (int c = 0; c < N; c++) begin
        if (g[c]) begin
          m_data  = bus_rr.src_data[c*DW +: DW];
          m_label = bus_rr.src_label[c*LW +: LW];
          m_ptr   = (c + 1) % N;
        end
      end
      m_valid = 1'b1;
      m_src   = g;
    end else begin
      m_valid = 1'b0;
      m_src   = '0;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive_rr(input int c, input logic v, input logic [31:0] d,
                          input logic [4:0] l);
    bus_rr.src_valid[c]           = v;
    bus_rr.src_data[c*DW +: DW]   = d;
    bus_rr.src_label[c*LW +: LW]  = l;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    for (int c = 0; c < N; c++) drive_rr(c, 1'b1, 32'h1000 + c, LW'(c + 1));
    bus_fx.src_valid = '0;
    bus_fx.src_data  = '0;
    bus_fx.src_label = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    total++; if (bus_rr.src_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", bus_rr.src_ready); end
    total++; if (bus_rr.cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus_rr.cdb_valid); end
    total++; if (bus_rr.cdb_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus_rr.cdb_data); end
    total++; if (bus_rr.cdb_label !== 5'h0) begin bad++; $display("FAIL reset_label: got %h want 0", bus_rr.cdb_label); end
    total++; if (bus_rr.cdb_src !== 4'b0000) begin bad++; $display("FAIL reset_src: got %b want 0000", bus_rr.cdb_src); end
    total++; if (dbg_ptr_rr !== 2'd0) begin bad++; $display("FAIL reset_ptr: got %0d want 0", dbg_ptr_rr); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    total++; if (bus_rr.src_ready !== 4'b0001) begin bad++; $display("FAIL first_grant: got %b want 0001", bus_rr.src_ready); end
    model_tick();
    total++; if (bus_rr.cdb_src !== 4'b0001 || bus_rr.cdb_data !== 32'h1000) begin bad++; $display("FAIL first_bcast: got src=%b data=%h want src=0001 data=00001000", bus_rr.cdb_src, bus_rr.cdb_data); end
    bus_rr.src_valid = '0;
    model_tick();
  endtask

  task automatic test_single();
    drive_rr(2, 1'b1, 32'hDEADBEEF, 5'd9);
    #1;
    total++; if (bus_rr.src_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", bus_rr.src_ready); end
    model_tick();
    bus_rr.src_valid = '0;
    total++; if (bus_rr.cdb_valid !== 1'b1 || bus_rr.cdb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got v=%b d=%h want v=1 d=deadbeef", bus_rr.cdb_valid, bus_rr.cdb_data); end
    total++; if (bus_rr.cdb_label !== 5'd9 || bus_rr.cdb_src !== 4'b0100) begin bad++; $display("FAIL single_label: got l=%0d s=%b want l=9 s=0100", bus_rr.cdb_label, bus_rr.cdb_src); end
    model_tick();
    total++; if (bus_rr.cdb_valid !== 1'b0 || bus_rr.cdb_src !== 4'b0000) begin bad++; $display("FAIL single_idle: got v=%b s=%b want v=0 s=0000", bus_rr.cdb_valid, bus_rr.cdb_src); end
    total++; if (bus_rr.cdb_data !== 32'hDEADBEEF || bus_rr.cdb_label !== 5'd9) begin bad++; $display("FAIL single_hold: got d=%h l=%0d want d=deadbeef l=9", bus_rr.cdb_data, bus_rr.cdb_label); end
  endtask

  task automatic test_wrap();
    total++; if (dbg_ptr_rr !== 2'(m_ptr) || m_ptr != 3) begin bad++; $display("FAIL wrap_ptr_start: got %0d want 3", dbg_ptr_rr); end
    drive_rr(0, 1'b1, 32'hA0, 5'd1);
    drive_rr(1, 1'b1, 32'hA1, 5'd2);
    #1;
    total++; if (bus_rr.src_ready !== 4'b0001) begin bad++; $display("FAIL wrap_grant0: got %b want 0001", bus_rr.src_ready); end
    model_tick();
    total++; if (dbg_ptr_rr !== 2'd1) begin bad++; $display("FAIL wrap_ptr1: got %0d want 1", dbg_ptr_rr); end
    total++; if (bus_rr.src_ready !== 4'b0010) begin bad++; $display("FAIL wrap_grant1: got %b want 0010", bus_rr.src_ready); end
    model_tick();
    total++; if (dbg_ptr_rr !== 2'd2) begin bad++; $display("FAIL wrap_ptr2: got %0d want 2", dbg_ptr_rr); end
    bus_rr.src_valid = '0;
  endtask

  task automatic test_fairness();
    drive_rr(3, 1'b1, 32'hB3, 5'd7);
    model_tick();
    for (int c = 0; c < N; c++) drive_rr(c, 1'b1, 32'hC0 + c, LW'(16 + c));
    #1;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] want;
      want = '0;
      want[i % N] = 1'b1;
      total++; if (bus_rr.src_ready !== want) begin bad++; $display("FAIL rr_order[%0d]: got %b want %b", i, bus_rr.src_ready, want); end
      model_tick();
      total++; if (bus_rr.cdb_valid !== 1'b1 || bus_rr.cdb_src !== want || bus_rr.cdb_data !== m_data) begin bad++; $display("FAIL rr_bcast[%0d]: got v=%b s=%b d=%h want v=1 s=%b d=%h", i, bus_rr.cdb_valid, bus_rr.cdb_src, bus_rr.cdb_data, want, m_data); end
    end
  endtask

  task automatic test_flush();
    logic [1:0] ptr_before;
    ptr_before = dbg_ptr_rr;
    bus_rr.src_valid = 4'b0110;
    flush = 1'b1;
    #1;
    total++; if (bus_rr.src_ready !== 4'b0000) begin bad++; $display("FAIL flush_ready: got %b want 0000", bus_rr.src_ready); end
    total++; if (bus_rr.cdb_valid !== 1'b1) begin bad++; $display("FAIL flush_present: got %b want 1", bus_rr.cdb_valid); end
    model_tick();
    flush = 1'b0;
    total++; if (bus_rr.cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_next: got %b want 0", bus_rr.cdb_valid); end
    total++; if (dbg_ptr_rr !== ptr_before || dbg_ptr_rr !== 2'(m_ptr)) begin bad++; $display("FAIL flush_ptr: got %0d want %0d", dbg_ptr_rr, m_ptr); end
    #1;
    total++; if (bus_rr.src_ready !== ref_grant(4'b0110, m_ptr, 1'b1, 1'b0)) begin bad++; $display("FAIL flush_resume: got %b want %b", bus_rr.src_ready, ref_grant(4'b0110, m_ptr, 1'b1, 1'b0)); end
    bus_rr.src_valid = '0;
    model_tick();
  endtask

  task automatic test_fixed();
    bus_fx.src_valid = 4'b1011;
    for (int c = 0; c < N; c++) begin
      bus_fx.src_data[c*DW +: DW]  = 32'hF0 + c;
      bus_fx.src_label[c*LW +: LW] = LW'(20 + c);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus_fx.src_ready !== ref_grant(4'b1011, 0, 1'b0, 1'b0)) begin bad++; $display("FAIL fixed_ready[%0d]: got %b want 1000", i, bus_fx.src_ready); end
      model_tick();
      total++; if (bus_fx.cdb_src !== 4'b1000 || bus_fx.cdb_data !== 32'hF3 || bus_fx.cdb_label !== 5'd23) begin bad++; $display("FAIL fixed_bcast[%0d]: got s=%b d=%h l=%0d want s=1000 d=f3 l=23", i, bus_fx.cdb_src, bus_fx.cdb_data, bus_fx.cdb_label); end
      total++; if (dbg_ptr_fx !== 2'd0) begin bad++; $display("FAIL fixed_ptr[%0d]: got %0d want 0", i, dbg_ptr_fx); end
    end
    bus_fx.src_valid = 4'b0011;
    #1;
    total++; if (bus_fx.src_ready !== 4'b0010) begin bad++; $display("FAIL fixed_low: got %b want 0010", bus_fx.src_ready); end
    bus_fx.src_valid = '0;
    model_tick();
  endtask

  task automatic test_random();
    logic [3:0] g;
    logic [31:0] want_d;
    for (int c = 0; c < N; c++) drive_rr(c, 1'b0, 32'h0, 5'h0);
    exp_q.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      // Idle or just-granted producers may present a new result.
      for (int c = 0; c < N; c++) begin
        if (!bus_rr.src_valid[c] || m_src[c]) begin
          if ($urandom_range(0, 2) != 0)
            drive_rr(c, 1'b1, $urandom, LW'($urandom_range(0, 31)));
          else
            bus_rr.src_valid[c] = 1'b0;
        end
      end
      flush = ($urandom_range(0, 7) == 0);
      #1;
      g = ref_grant(bus_rr.src_valid, m_ptr, 1'b1, flush);
      total++; if (bus_rr.src_ready !== g) begin bad++; $display("FAIL rand_ready[%0d]: got %b want %b", cyc, bus_rr.src_ready, g); end
      for (int c = 0; c < N; c++) if (g[c]) exp_q.push_back(bus_rr.src_data[c*DW +: DW]);
      model_tick();
      total++; if (bus_rr.cdb_valid !== m_valid || bus_rr.cdb_src !== m_src || bus_rr.cdb_label !== m_label || dbg_ptr_rr !== 2'(m_ptr)) begin bad++; $display("FAIL rand_cdb[%0d]: got v=%b s=%b l=%0d p=%0d want v=%b s=%b l=%0d p=%0d", cyc, bus_rr.cdb_valid, bus_rr.cdb_src, bus_rr.cdb_label, dbg_ptr_rr, m_valid, m_src, m_label, m_ptr); end
      if (bus_rr.cdb_valid === 1'b1) begin
        want_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        total++; if (bus_rr.cdb_data !== want_d) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", cyc, bus_rr.cdb_data, want_d); end
      end
    end
    flush = 1'b0;
    bus_rr.src_valid = '0;
    model_tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    drive_rr(1, 1'b1, 32'h5555AAAA, 5'd3);
    model_tick();
    bus_rr.src_valid = 4'b1111;
    total++; if (bus_rr.cdb_valid !== 1'b1) begin bad++; $display("FAIL arst_pre: got %b want 1", bus_rr.cdb_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus_rr.cdb_valid !== 1'b0 || bus_rr.cdb_data !== 32'h0) begin bad++; $display("FAIL arst_clear: got v=%b d=%h want v=0 d=0", bus_rr.cdb_valid, bus_rr.cdb_data); end
    total++; if (bus_rr.src_ready !== 4'b0000) begin bad++; $display("FAIL arst_ready: got %b want 0000", bus_rr.src_ready); end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    total++; if (bus_rr.src_ready !== 4'b0001) begin bad++; $display("FAIL arst_regrant: got %b want 0001", bus_rr.src_ready); end
    model_tick();
    bus_rr.src_valid = '0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus_rr.src_valid = '0;
    bus_rr.src_data  = '0;
    bus_rr.src_label = '0;
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_flush();
    test_fixed();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
